// File: rtl/mask_rle_encoder.sv
// rtl/mask_rle_encoder.sv - run-length encodes raster segment IDs into 40-bit mask records
// and serializes them as paced 16-bit ioctl words for the mask loader.
module mask_rle_encoder #(
    parameter int FIFO_DEPTH      = 4,
    parameter int WR_GAP          = 3,
    parameter int EMIT_TERMINATOR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [9:0]  pix_id,
    input  logic        pix_present,
    input  logic        flush,
    output logic        ioctl_wr,
    output logic [15:0] ioctl_dout,
    output logic        busy,
    output logic        done
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int GW = $clog2(WR_GAP + 1);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FIFO_ROOM2 = CW'(FIFO_DEPTH - 2);
    localparam logic [GW-1:0] GAP_MAX    = GW'(WR_GAP);
    localparam logic [GW-1:0] GAP_OK     = GW'(WR_GAP - 1);
    localparam logic [39:0]   TERM_REC   = {10'd1, 10'h3FF, 10'h3FF, 10'd0};

    typedef enum logic [1:0] {S_IDLE, S_TERM, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    logic          run_open_q;
    logic [9:0]    run_id_q, run_x0_q, run_y_q, run_len_q, run_last_x_q;
    logic [39:0]   fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] fifo_cnt_q;
    logic [47:0]   buf_q;
    logic [2:0]    buf_cnt_q;
    logic [GW-1:0] gap_q;
    logic          wr_q;
    logic [15:0]   dout_q;

    logic        accept, flush_go, extend, close_run, term_push, push, pop;
    logic        gap_ok, emit_word, emit_pad, fire;
    logic [39:0] push_rec;

    assign accept    = pix_valid && pix_ready;
    assign flush_go  = flush && !pix_valid && (state_q == S_IDLE);
    // Widened compare so last_x = 1023 never wraps into a continuation at x = 0.
    assign extend    = run_open_q && (pix_id == run_id_q) && (pix_y == run_y_q)
                     && ({1'b0, pix_x} == ({1'b0, run_last_x_q} + 11'd1))
                     && (run_len_q != 10'h3FF);
    assign close_run = run_open_q && ((accept && !(pix_present && extend)) || flush_go);
    assign term_push = (state_q == S_TERM) && (fifo_cnt_q != FIFO_FULL);
    assign push      = close_run || term_push;
    assign push_rec  = term_push ? TERM_REC : {run_len_q, run_y_q, run_x0_q, run_id_q};
    // buf_q holds at most one carried byte below a freshly loaded record.
    assign pop       = (fifo_cnt_q != '0) && (buf_cnt_q <= 3'd1);
    assign gap_ok    = gap_q >= GAP_OK;
    assign emit_word = (buf_cnt_q >= 3'd2) && gap_ok;
    assign emit_pad  = (state_q == S_DRAIN) && (fifo_cnt_q == '0) && (buf_cnt_q == 3'd1) && gap_ok;
    assign fire      = emit_word || emit_pad;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (flush_go) state_d = (EMIT_TERMINATOR != 0) ? S_TERM : S_DRAIN;
            S_TERM:  if (term_push) state_d = S_DRAIN;
            S_DRAIN: if ((fifo_cnt_q == '0) && (buf_cnt_q == 3'd0)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pix_ready = !reset && (fifo_cnt_q <= FIFO_ROOM2) && (state_q == S_IDLE);
        busy      = run_open_q || (fifo_cnt_q != '0) || (buf_cnt_q != 3'd0)
                  || (state_q == S_TERM) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= push_rec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_open_q   <= 1'b0;
            run_id_q     <= '0;
            run_x0_q     <= '0;
            run_y_q      <= '0;
            run_len_q    <= '0;
            run_last_x_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            buf_q        <= '0;
            buf_cnt_q    <= '0;
            gap_q        <= GAP_MAX;
            wr_q         <= 1'b0;
            dout_q       <= '0;
        end else begin
            if (accept && pix_present) begin
                if (extend) begin
                    run_len_q    <= run_len_q + 10'd1;
                    run_last_x_q <= pix_x;
                end else begin
                    run_open_q   <= 1'b1;
                    run_id_q     <= pix_id;
                    run_x0_q     <= pix_x;
                    run_y_q      <= pix_y;
                    run_len_q    <= 10'd1;
                    run_last_x_q <= pix_x;
                end
            end else if (accept || flush_go) begin
                run_open_q <= 1'b0;
            end

            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);

            if (pop) begin
                buf_q     <= (buf_cnt_q == 3'd1) ? {fifo_mem_q[rd_ptr_q], buf_q[7:0]}
                                                 : {8'h00, fifo_mem_q[rd_ptr_q]};
                buf_cnt_q <= buf_cnt_q + 3'd5;
            end else if (fire) begin
                buf_q     <= {16'h0000, buf_q[47:16]};
                buf_cnt_q <= emit_pad ? 3'd0 : buf_cnt_q - 3'd2;
            end

            wr_q <= fire;
            if (fire) dout_q <= emit_pad ? {8'h00, buf_q[7:0]} : buf_q[15:0];
            gap_q <= fire ? '0 : ((gap_q == GAP_MAX) ? gap_q : gap_q + GW'(1));
        end
    end

    assign ioctl_wr   = wr_q && !reset;
    assign ioctl_dout = dout_q;

endmodule

// File: tb/tb_mask_rle_encoder.sv
// tb/tb_mask_rle_encoder.sv - directed and randomized frames for mask_rle_encoder,
// compared word-for-word against a record/byte-stream model of the mask format.
`timescale 1ns/1ps
module tb_mask_rle_encoder;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] id;
        logic       present;
    } pix_t;

    logic        clk = 1'b0, reset = 1'b1, pix_valid = 1'b0, pix_present = 1'b0, flush = 1'b0;
    logic [9:0]  pix_x = '0, pix_y = '0, pix_id = '0;
    logic        rdy_a, wr_a, busy_a, done_a, rdy_b, wr_b, busy_b, done_b;
    logic [15:0] dout_a, dout_b;

    int checks = 0, errors = 0, cyc = 0;
    logic [15:0] obs_a[$], obs_b[$];
    int wrc_a[$], wrc_b[$];
    int done_cnt_a = 0, done_cnt_b = 0, gap_err_a = 0, gap_err_b = 0, rst_wr_err = 0;
    int last_wr_a = -1000, last_wr_b = -1000;

    mask_rle_encoder #(.FIFO_DEPTH(4), .WR_GAP(3), .EMIT_TERMINATOR(1)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(rdy_a),
        .pix_x(pix_x), .pix_y(pix_y), .pix_id(pix_id), .pix_present(pix_present),
        .flush(flush), .ioctl_wr(wr_a), .ioctl_dout(dout_a), .busy(busy_a), .done(done_a));

    mask_rle_encoder #(.FIFO_DEPTH(4), .WR_GAP(3), .EMIT_TERMINATOR(0)) dut_nt (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(rdy_b),
        .pix_x(pix_x), .pix_y(pix_y), .pix_id(pix_id), .pix_present(pix_present),
        .flush(flush), .ioctl_wr(wr_b), .ioctl_dout(dout_b), .busy(busy_b), .done(done_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (wr_a || wr_b) rst_wr_err <= rst_wr_err + 1;
            last_wr_a <= -1000;
            last_wr_b <= -1000;
        end else begin
            if (wr_a) begin
                obs_a.push_back(dout_a);
                wrc_a.push_back(cyc);
                if (cyc - last_wr_a < 3) gap_err_a <= gap_err_a + 1;
                last_wr_a <= cyc;
            end
            if (wr_b) begin
                obs_b.push_back(dout_b);
                wrc_b.push_back(cyc);
                if (cyc - last_wr_b < 3) gap_err_b <= gap_err_b + 1;
                last_wr_b <= cyc;
            end
            if (done_a) done_cnt_a <= done_cnt_a + 1;
            if (done_b) done_cnt_b <= done_cnt_b + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] mkrec(input int len, input int y, input int x, input int id);
        return {len[9:0], y[9:0], x[9:0], id[9:0]};
    endfunction

    function automatic pix_t mkpix(input int x, input int y, input int id, input bit p);
        return pix_t'({x[9:0], y[9:0], id[9:0], p});
    endfunction

    // Records from the run rules, then LSB-first bytes packed two per word.
    function automatic void model(input pix_t px[$], input bit term, output logic [15:0] w[$]);
        logic [39:0] recs[$];
        logic [7:0]  bytes[$];
        bit open;
        int len, x0, lx, ry, rid;
        open = 0; len = 0; x0 = 0; lx = 0; ry = 0; rid = 0;
        w = {};
        foreach (px[i]) begin
            if (px[i].present) begin
                if (open && int'(px[i].id) == rid && int'(px[i].y) == ry
                    && int'(px[i].x) == lx + 1 && len < 1023) begin
                    len++;
                    lx = int'(px[i].x);
                end else begin
                    if (open) recs.push_back(mkrec(len, ry, x0, rid));
                    open = 1; len = 1;
                    x0 = int'(px[i].x); lx = x0; ry = int'(px[i].y); rid = int'(px[i].id);
                end
            end else if (open) begin
                recs.push_back(mkrec(len, ry, x0, rid));
                open = 0;
            end
        end
        if (open) recs.push_back(mkrec(len, ry, x0, rid));
        if (term) recs.push_back(mkrec(1, 1023, 1023, 0));
        foreach (recs[r]) for (int b = 0; b < 5; b++) bytes.push_back(recs[r][8*b +: 8]);
        for (int i = 0; i < bytes.size(); i += 2)
            w.push_back({(i + 1 < bytes.size()) ? bytes[i+1] : 8'h00, bytes[i]});
    endfunction

    function automatic void gen_rand(output pix_t q[$], input int n);
        int x, y, id, r;
        x = $urandom_range(0, 1000); y = $urandom_range(0, 40); id = $urandom_range(0, 3);
        q = {};
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 6) id = $urandom_range(0, 3);
            else if (r == 7) x = $urandom_range(0, 1022);
            else if (r == 8) y = y + 1;
            q.push_back(mkpix(x, y, id, r != 9));
            x = (x >= 1023) ? 0 : x + 1;
        end
    endfunction

    task automatic drive_pixels(input pix_t px[$], input bit flush_first,
                                output int stalls, output int last_cyc);
        int t;
        stalls = 0; last_cyc = 0;
        foreach (px[i]) begin
            t = 0;
            @(negedge clk);
            while (!(rdy_a && rdy_b) && t < 2000) begin
                pix_valid = 1'b0; flush = 1'b0;
                stalls++; t++;
                @(negedge clk);
            end
            if (t >= 2000) begin
                check("pix_ready_timeout", 32'(rdy_a && rdy_b), 32'd1);
                break;
            end
            pix_valid   = 1'b1;
            pix_x       = px[i].x;
            pix_y       = px[i].y;
            pix_id      = px[i].id;
            pix_present = px[i].present;
            flush       = flush_first && (i == 0);
            last_cyc    = cyc;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic pulse_flush();
        pix_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic run_frame(input string name, input pix_t px[$], input bit flush_first,
                             input bit dbl_flush, output int stalls, output int last_cyc);
        logic [15:0] exp_a[$], exp_b[$];
        int ba, bb, da, db, ga, gb, t;
        model(px, 1'b1, exp_a);
        model(px, 1'b0, exp_b);
        ba = obs_a.size(); bb = obs_b.size();
        da = done_cnt_a;  db = done_cnt_b;
        ga = gap_err_a;   gb = gap_err_b;
        drive_pixels(px, flush_first, stalls, last_cyc);
        pulse_flush();
        if (dbl_flush) begin
            repeat (2) @(negedge clk);
            pulse_flush();
        end
        t = 0;
        while ((done_cnt_a == da || done_cnt_b == db) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s done_wait", name), 32'(t < 20000), 32'd1);
        repeat (6) @(negedge clk);
        check($sformatf("%s done_pulses_a", name), 32'(done_cnt_a - da), 32'd1);
        check($sformatf("%s done_pulses_b", name), 32'(done_cnt_b - db), 32'd1);
        check($sformatf("%s busy_a", name), 32'(busy_a), 32'd0);
        check($sformatf("%s busy_b", name), 32'(busy_b), 32'd0);
        check($sformatf("%s nwords_a", name), 32'(obs_a.size() - ba), 32'(exp_a.size()));
        check($sformatf("%s nwords_b", name), 32'(obs_b.size() - bb), 32'(exp_b.size()));
        for (int i = 0; i < exp_a.size(); i++)
            if (ba + i < obs_a.size())
                check($sformatf("%s word_a[%0d]", name, i), 32'(obs_a[ba+i]), 32'(exp_a[i]));
        for (int i = 0; i < exp_b.size(); i++)
            if (bb + i < obs_b.size())
                check($sformatf("%s word_b[%0d]", name, i), 32'(obs_b[bb+i]), 32'(exp_b[i]));
        check($sformatf("%s gap_a", name), 32'(gap_err_a - ga), 32'd0);
        check($sformatf("%s gap_b", name), 32'(gap_err_b - gb), 32'd0);
    endtask

    pix_t q[$];
    int stalls, lc, ba, bb, t;
    logic [15:0] k1[5];
    logic [15:0] k2[5];
    logic [15:0] k3[5];

    initial begin
        k1 = '{16'h2807, 16'hC050, 16'h0000, 16'hFFFC, 16'h007F};
        k2 = '{16'h0001, 16'h8000, 16'h0200, 16'h0008, 16'h0040};
        k3 = '{16'h0003, 16'hC000, 16'h03FF, 16'h0FFC, 16'h0040};

        repeat (3) @(negedge clk);
        check("rst ioctl_wr", 32'(wr_a), 32'd0);
        check("rst ioctl_dout", 32'(dout_a), 32'd0);
        check("rst done", 32'(done_a), 32'd0);
        check("rst busy", 32'(busy_a), 32'd0);
        check("rst pix_ready_a", 32'(rdy_a), 32'd0);
        check("rst pix_ready_b", 32'(rdy_b), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst pix_ready", 32'(rdy_a), 32'd1);

        // Single run plus absent pixel; a second flush mid-drain must be ignored.
        q = {mkpix(10, 5, 7, 1), mkpix(11, 5, 7, 1), mkpix(12, 5, 7, 1), mkpix(13, 5, 7, 0)};
        ba = obs_a.size(); bb = obs_b.size();
        run_frame("single_run", q, 1'b0, 1'b1, stalls, lc);
        for (int i = 0; i < 5; i++)
            if (ba + i < obs_a.size())
                check($sformatf("single_run const[%0d]", i), 32'(obs_a[ba+i]), 32'(k1[i]));
        if (ba < wrc_a.size()) check("close_latency_a", 32'(wrc_a[ba]), 32'(lc + 3));
        if (bb < wrc_b.size()) check("close_latency_b", 32'(wrc_b[bb]), 32'(lc + 3));

        q = {mkpix(0, 0, 1, 1), mkpix(1, 0, 1, 1), mkpix(2, 0, 2, 1)};
        bb = obs_b.size();
        run_frame("id_split", q, 1'b0, 1'b0, stalls, lc);
        check("id_split nt_words", 32'(obs_b.size() - bb), 32'd5);
        for (int i = 0; i < 5; i++)
            if (bb + i < obs_b.size())
                check($sformatf("id_split const[%0d]", i), 32'(obs_b[bb+i]), 32'(k2[i]));

        q = {};
        for (int x = 0; x < 1024; x++) q.push_back(mkpix(x, 0, 3, 1));
        bb = obs_b.size();
        run_frame("len_cap", q, 1'b0, 1'b0, stalls, lc);
        for (int i = 0; i < 5; i++)
            if (bb + i < obs_b.size())
                check($sformatf("len_cap const[%0d]", i), 32'(obs_b[bb+i]), 32'(k3[i]));

        // First pixel carries a flush that must be ignored because pix_valid is high.
        q = {};
        for (int x = 1020; x < 1024; x++) q.push_back(mkpix(x, 1, 9, 1));
        q.push_back(mkpix(0, 2, 9, 1));
        q.push_back(mkpix(4, 2, 9, 1));
        q.push_back(mkpix(6, 2, 9, 1));
        bb = obs_b.size();
        run_frame("row_gap", q, 1'b1, 1'b0, stalls, lc);
        check("row_gap nt_words", 32'(obs_b.size() - bb), 32'd10);

        q = {};
        for (int x = 0; x < 40; x++) q.push_back(mkpix(x, 7, (x % 2 == 0) ? 5 : 6, 1));
        run_frame("backpressure", q, 1'b0, 1'b0, stalls, lc);
        check("backpressure stalled", 32'(stalls > 0), 32'd1);

        for (int f = 0; f < 6; f++) begin
            gen_rand(q, $urandom_range(20, 60));
            run_frame($sformatf("rand%0d", f), q, 1'b0, 1'b0, stalls, lc);
        end

        q = {};
        for (int x = 0; x < 12; x++) q.push_back(mkpix(x, 3, (x % 2 == 0) ? 1 : 2, 1));
        ba = obs_a.size();
        drive_pixels(q, 1'b0, stalls, lc);
        t = 0;
        while (obs_a.size() < ba + 3 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("mid_reset burst_seen", 32'(t < 3000), 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_reset pix_ready", 32'(rdy_a), 32'd0);
        reset = 1'b0;
        q = {mkpix(5, 9, 33, 1)};
        run_frame("post_reset", q, 1'b0, 1'b0, stalls, lc);
        check("no_wr_in_reset", 32'(rst_wr_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mask_rle_encoder.md
# mask_rle_encoder

Producer side of the mask ROM load stream. It accepts a raster-order stream of per-pixel segment IDs, run-length encodes horizontal runs into 40-bit mask records, and serializes them as 16-bit `ioctl`-style words. Word order and pacing match exactly what the mask loader consumes. It sits between a raw-mask source (image decoder or test generator) and the mask loader, and lets the design build the mask ROM from an uncompressed mask image.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: record FIFO entries; power of two, ≥2.
- `WR_GAP`, default 3: minimum clk cycles from one `ioctl_wr` pulse to the next; must be ≥3.
- `EMIT_TERMINATOR`, default 1: when 1, append the terminator record on flush.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `pix_valid` in 1: pixel beat valid.
- `pix_ready` out 1: pixel beat accepted when valid && ready.
- `pix_x` in 10: pixel column.
- `pix_y` in 10: pixel row.
- `pix_id` in 10: segment ID.
- `pix_present` in 1: pixel belongs to a segment.
- `flush` in 1: one-cycle pulse at end of frame; only honored when `pix_valid` is 0.
- `ioctl_wr` out 1: one-cycle word strobe.
- `ioctl_dout` out 16: word, valid when `ioctl_wr`.
- `busy` out 1: open run, FIFO non-empty, serializer active, or flush in progress.
- `done` out 1: one-cycle pulse after the last word of a flush is sent.

## Operation
- **Record layout:** bits [39:30] length, [29:20] y, [19:10] start_x, [9:0] id. Bytes are sent LSB byte first and packed contiguously across records. Each word is {second byte, first byte}; a record may straddle words.
- **Run tracking:** the encoder holds an open run: id, x0, y, len, plus last x.
- **Accepted pixel with `pix_present`=1 extends the open run** when all of these hold: the run is open, `pix_id` == id, `pix_y` == y, `pix_x` == last_x+1, and len < 1023. The extension is len+1.
- **Otherwise** the encoder closes any open run, pushes it as a record, and opens a new run with len=1.
- **Accepted pixel with `pix_present`=0** closes any open run. No new run is opened.
- **Length cap:** length never exceeds 1023. The 1024th contiguous pixel starts a new record.
- **Zero-length records are never emitted.**
- **`pix_ready`** = ~reset && FIFO has ≥2 free entries && flush not in progress. Two free entries are required because one pixel can close a run and a flush can follow immediately.
- **Flush sequence:**
  1. Close the open run.
  2. If `EMIT_TERMINATOR` is set, push the terminator record: id 0, x 0x3FF, y 0x3FF, len 1.
  3. Drain the FIFO and the serializer.
  4. If one byte is left over, send it as word {0x00, byte}.
  5. Pulse `done`. `busy` falls on the same cycle.
- **Serializer:** pops a record when the 5-byte shift register is empty. It forms a word when 2 bytes are available, or 1 byte at flush end. It asserts `ioctl_wr` only if at least `WR_GAP` cycles have passed since the previous strobe.
- **Reset:** clears the run, FIFO, serializer, byte carry, and gap counter. Mid-frame data is discarded and no partial word is emitted. The gap counter is treated as satisfied after reset.

## Timing
- **Reset values:** `ioctl_wr`=0, `ioctl_dout`=0, `done`=0, `busy`=0. `pix_ready`=0 while reset is high and 1 on the first cycle after.
- **Closing-run latency:**
  - Pixel that closes a run is accepted at cycle N.
  - Record is in the FIFO at N+1.
  - Record is loaded into the serializer at N+2, if the serializer is idle.
  - First `ioctl_wr` is at N+3, gap permitting.
- **Record cost:** 5 bytes per record. A steady stream is limited to 2 bytes per `WR_GAP` cycles; back-pressure is via `pix_ready`.
- **Same-cycle close and open:** closing a run and opening a new one in the same cycle is a single FIFO push plus a run-register load. There is no bubble.
- **`flush` with `pix_valid`=1:** flush is ignored.
- **`flush` while busy:** a second `flush` is ignored.
- **`ioctl_dout`** holds its last value between strobes.

## Test plan
- **Single run with terminator:** row y=5, x=10..12 id=7 present, then x=13 absent, then `flush`. Required words in order: 0x2807, 0xC050, 0x0000, 0xFFFC, 0x007F, then `done`. Each word strobe must be ≥3 cycles apart.
- **Run split on ID change:** y=0, x=0,1 id=1 then x=2 id=2, flush with `EMIT_TERMINATOR`=0. Required records: {len2,y0,x0,id1} and {len1,y0,x2,id2}. The 10 bytes are packed into exactly 5 words with no pad word.
- **Length cap:** y=0, x=0..1023 all id=3. Required records: {len1023,x0} then {len1,x1023}.
- **Row change and gap:** run at y=1 x=1020..1023, then y=2 x=0. The encoder must emit two separate records. A gap at x (x=4 then x=6, same id) must also produce two records.
- **Back-pressure:** alternate id every pixel with `pix_valid` held high. `pix_ready` must drop so the FIFO never overflows. Every record must appear exactly once, in order, and `ioctl_wr` spacing must be ≥ `WR_GAP`.
- **Reset mid-operation:** assert `reset` during a word burst. No strobe is allowed while reset is high. After release, a new single-pixel frame must produce only its own words.
